// File: rtl/accum_mem_pkg.sv
// Shared types and helpers for the accumulate accelerator's memory responder.
// Address layout: byte address, word index in bits [15:2].
package accum_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = ADDR_W - 2;

    typedef struct packed {
        logic              val;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

    // Legal means word aligned and inside the populated part of the array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                     input int unsigned       depth);
        return (addr[1:0] == 2'b00) && (32'(addr[ADDR_W-1:2]) < depth);
    endfunction

endpackage

// File: rtl/accum_mem_pipe.sv
// LATENCY-deep response shift register; the last entry drives the response port.
module accum_mem_pipe
    import accum_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t stage_in,
    output resp_t stage_out
);

    resp_t stage_q [LATENCY];
    resp_t stage_d [LATENCY];

    // Next-state of every entry: new response enters entry 0, the rest shift down.
    always_comb begin
        stage_d[0] = stage_in;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers; reset discards all in-flight responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign stage_out = stage_q[LATENCY-1];

endmodule

// File: rtl/accum_mem_resp.sv
// Word-addressed memory responder for the accumulate accelerator: fixed-latency
// reads with error flagging, a side write port and a saturating request counter.
module accum_mem_resp
    import accum_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreq_val,
    input  logic [ADDR_W-1:0] memreq_addr,
    output logic              memresp_val,
    output logic [DATA_W-1:0] memresp_data,
    output logic              memresp_err,
    input  logic              wr_val,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       req_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic [DATA_W-1:0] rd_word_s;
    resp_t             stage_in_s;
    resp_t             stage_out_s;
    logic [15:0]       req_count_d;
    logic [15:0]       req_count_q;

    assign rd_idx_s = memreq_addr[ADDR_W-1:2];
    assign wr_idx_s = wr_addr[ADDR_W-1:2];
    assign rd_ok_s  = addr_ok(memreq_addr, DEPTH);
    assign wr_ok_s  = addr_ok(wr_addr, DEPTH);

    // Array read with write-first forwarding on a same-index collision.
    always_comb begin
        rd_word_s = mem_q[rd_idx_s[AW-1:0]];
        if (wr_val && wr_ok_s && (wr_idx_s == rd_idx_s)) begin
            rd_word_s = wr_data;
        end else begin
            rd_word_s = mem_q[rd_idx_s[AW-1:0]];
        end
    end

    // Build the stage-0 entry; bubbles and errored requests carry zero data.
    always_comb begin
        stage_in_s = '0;
        if (memreq_val) begin
            stage_in_s.val  = 1'b1;
            stage_in_s.err  = !rd_ok_s;
            stage_in_s.data = rd_ok_s ? rd_word_s : 32'h0000_0000;
        end else begin
            stage_in_s = '0;
        end
    end

    // Storage array is deliberately unreset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_val && wr_ok_s) begin
            mem_q[wr_idx_s[AW-1:0]] <= wr_data;
        end
    end

    // Saturating count of accepted requests, errored ones included.
    always_comb begin
        req_count_d = req_count_q;
        if (memreq_val && (req_count_q != 16'hFFFF)) begin
            req_count_d = req_count_q + 16'd1;
        end else begin
            req_count_d = req_count_q;
        end
    end

    // Request counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_count_q <= 16'd0;
        end else begin
            req_count_q <= req_count_d;
        end
    end

    accum_mem_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .stage_in  (stage_in_s),
        .stage_out (stage_out_s)
    );

    assign memresp_val  = stage_out_s.val;
    assign memresp_err  = stage_out_s.err;
    assign memresp_data = stage_out_s.data;
    assign req_count    = req_count_q;

endmodule

// File: tb/tb_accum_mem_resp.sv
// Directed bench for accum_mem_resp: a LATENCY=1 and a LATENCY=3 instance share
// all stimulus; outputs are sampled on the falling clock edge.
module tb_accum_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreq_val;
    logic [15:0] memreq_addr;
    logic        wr_val;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    logic        val1, err1, val3, err3;
    logic [31:0] data1, data3;
    logic [15:0] cnt1, cnt3;

    int checks = 0;
    int errors = 0;
    logic [31:0] acc;

    always #5 clk = ~clk;

    accum_mem_resp #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .memreq_val(memreq_val), .memreq_addr(memreq_addr),
        .memresp_val(val1), .memresp_data(data1), .memresp_err(err1),
        .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_count(cnt1)
    );

    accum_mem_resp #(.DEPTH(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .memreq_val(memreq_val), .memreq_addr(memreq_addr),
        .memresp_val(val3), .memresp_data(data3), .memresp_err(err3),
        .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_count(cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp1(input string tag, input logic v, input logic e, input logic [31:0] d);
        check({tag, "_val1"}, 32'(val1), 32'(v));
        check({tag, "_err1"}, 32'(err1), 32'(e));
        check({tag, "_data1"}, data1, d);
    endtask

    initial begin
        rst = 1'b0; memreq_val = 1'b0; memreq_addr = 16'h0000;
        wr_val = 1'b0; wr_addr = 16'h0000; wr_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_val1", 32'(val1), 32'd0);
        check("rst_data1", data1, 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_val3", 32'(val3), 32'd0);
        check("rst_cnt3", 32'(cnt3), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Preload through the side port
        wr_val = 1'b1; wr_addr = 16'h0000; wr_data = 32'h11;
        @(negedge clk); wr_addr = 16'h0004; wr_data = 32'h22;
        @(negedge clk); wr_addr = 16'h0008; wr_data = 32'h33;
        @(negedge clk); wr_val = 1'b0;
        check("wr_no_req", 32'(cnt1), 32'd0);

        // Back-to-back reads, LATENCY=1
        memreq_val = 1'b1; memreq_addr = 16'h0000;
        @(negedge clk); check_resp1("rd0", 1'b1, 1'b0, 32'h11); memreq_addr = 16'h0004;
        @(negedge clk); check_resp1("rd4", 1'b1, 1'b0, 32'h22); memreq_addr = 16'h0008;
        @(negedge clk); check_resp1("rd8", 1'b1, 1'b0, 32'h33); memreq_val = 1'b0;
        @(negedge clk); check_resp1("bubble", 1'b0, 1'b0, 32'h0);
        check("cnt_after3", 32'(cnt1), 32'd3);
        repeat (3) @(negedge clk);
        check("l3_drained", 32'(val3), 32'd0);

        // Single read through the LATENCY=3 instance
        memreq_val = 1'b1; memreq_addr = 16'h0004;
        @(negedge clk); check("l3_n1_val", 32'(val3), 32'd0); memreq_val = 1'b0;
        @(negedge clk); check("l3_n2_val", 32'(val3), 32'd0);
        @(negedge clk); check("l3_n3_val", 32'(val3), 32'd1);
        check("l3_n3_data", data3, 32'h22);
        check("l3_n3_err", 32'(err3), 32'd0);
        @(negedge clk); check("l3_n4_val", 32'(val3), 32'd0);
        check("l3_n4_data", data3, 32'h0);

        // Misaligned and out-of-range requests
        memreq_val = 1'b1; memreq_addr = 16'h0006;
        @(negedge clk); check_resp1("misal", 1'b1, 1'b1, 32'h0); memreq_addr = 16'h1000;
        @(negedge clk); check_resp1("oor", 1'b1, 1'b1, 32'h0); memreq_val = 1'b0;
        check("cnt_err", 32'(cnt1), 32'd6);
        // Last legal index is in range
        wr_val = 1'b1; wr_addr = 16'h0FFC; wr_data = 32'hA5A5_0001;
        @(negedge clk); wr_val = 1'b0; memreq_val = 1'b1; memreq_addr = 16'h0FFC;
        @(negedge clk); check_resp1("last_idx", 1'b1, 1'b0, 32'hA5A5_0001);
        // Illegal write dropped: index 1024 aliases index 0 if not blocked
        memreq_val = 1'b0; wr_val = 1'b1; wr_addr = 16'h1000; wr_data = 32'hBAD0_0000;
        @(negedge clk); wr_addr = 16'h0002;
        @(negedge clk); wr_val = 1'b0; memreq_val = 1'b1; memreq_addr = 16'h0000;
        @(negedge clk); check_resp1("bad_wr_drop", 1'b1, 1'b0, 32'h11);

        // Write-first forwarding on same index
        wr_val = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEAD_BEEF; memreq_addr = 16'h0010;
        @(negedge clk); check_resp1("fwd", 1'b1, 1'b0, 32'hDEAD_BEEF); wr_val = 1'b0;
        @(negedge clk); check_resp1("fwd_reread", 1'b1, 1'b0, 32'hDEAD_BEEF);
        // Different indices in the same cycle
        wr_val = 1'b1; wr_addr = 16'h0014; wr_data = 32'h55; memreq_addr = 16'h0008;
        @(negedge clk); check_resp1("rw_diff_rd", 1'b1, 1'b0, 32'h33); wr_val = 1'b0;
        memreq_addr = 16'h0014;
        @(negedge clk); check_resp1("rw_diff_wr", 1'b1, 1'b0, 32'h55); memreq_val = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-flight on the LATENCY=3 instance
        memreq_val = 1'b1; memreq_addr = 16'h0000;
        @(negedge clk); memreq_addr = 16'h0004;
        @(negedge clk); memreq_addr = 16'h0008;
        @(negedge clk); memreq_val = 1'b0;
        check("mid_val3", 32'(val3), 32'd1);
        check("mid_data3", data3, 32'h11);
        #1 rst = 1'b0;
        #1;
        check("async_val3", 32'(val3), 32'd0);
        check("async_data3", data3, 32'h0);
        check("async_cnt3", 32'(cnt3), 32'd0);
        check("async_val1", 32'(val1), 32'd0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_val3", 32'(val3), 32'd0);
        end
        memreq_val = 1'b1; memreq_addr = 16'h0000;
        @(negedge clk); check_resp1("retained", 1'b1, 1'b0, 32'h11); memreq_val = 1'b0;

        // Accelerator-style accumulation of three words after a fresh reset
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        acc = 32'h0;
        memreq_val = 1'b1; memreq_addr = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (val1) acc = acc + data1;
            memreq_addr = 16'(i * 4);
            if (i == 3) memreq_val = 1'b0;
        end
        check("acc_result", acc, 32'h66);
        check("acc_cnt", 32'(cnt1), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_mem_resp.md
Name: accum_mem_resp

Overview:
- Word-addressed memory responder that services the memreq/memresp read interface driven by the accumulate accelerator.
- Accepts one read request per cycle and returns the addressed 32-bit word after a fixed, parameterised latency.
- Provides a side write port so benches and a future loader can preload array contents.
- Flags misaligned and out-of-range requests.
- Sits beside the accelerator in the xcel top and in unit test harnesses.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two, max 16384).
- LATENCY, 1, cycles from request to response (1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- memreq_val  in  1  read request valid this cycle.
- memreq_addr  in  16  byte address of request.
- memresp_val  out  1  response valid; asserted exactly LATENCY cycles after an accepted request.
- memresp_data  out  32  read data, valid when memresp_val=1.
- memresp_err  out  1  qualifies memresp_val; 1 means misaligned or out-of-range request.
- wr_val  in  1  side-port write enable.
- wr_addr  in  16  byte address of write.
- wr_data  in  32  write data.
- req_count  out  16  number of requests accepted since reset.

Behaviour:
- Reset (rst=0, asynchronous): the following clear to 0 immediately:
  - memresp_val, memresp_data, memresp_err, req_count;
  - all pipeline valid/err bits and pipeline data registers.
- Storage array is not reset; contents are undefined until written.
- Address decode for both ports: word index = addr[15:2].
  - misaligned = addr[1:0] != 0.
  - out-of-range = index >= DEPTH.
- Requests are always accepted; there is no backpressure. One request per cycle sustained, fully pipelined.
- Request path:
  - Stage 0 on the clk edge where memreq_val=1: capture error = misaligned | out-of-range.
  - If there is no error, read array[index] into stage 0.
  - If there is an error, stage 0 data = 32'h0000_0000.
- Pipeline: a shift register of LATENCY entries {val, err, data}.
  - memresp_* are the outputs of the final entry.
  - LATENCY=1: request at edge N, response visible after edge N (cycle N+1), matching the accelerator's next-cycle data expectation.
- memreq_val=0: a bubble (val=0) enters the pipeline. memresp_data is held at 0 when memresp_val=0.
- Write port:
  - On an edge with wr_val=1 and a legal address, array[index] <= wr_data.
  - Illegal write addresses are silently dropped; no error output.
- Same-cycle write and read to the same legal index: the read returns wr_data (write-first forwarding).
- Read and write to different indices in the same cycle: both complete independently.
- req_count increments by 1 on each edge with memreq_val=1, including error requests. It saturates at 16'hFFFF.
- Reset mid-stream: in-flight responses are discarded. After rst deasserts, no spurious memresp_val. Array contents written before the reset are retained.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package accum_mem_pkg:
  - ADDR_W=16, DATA_W=32, word-index extraction width;
  - typedef struct resp_t {val, err, data};
  - helper function for addr_ok.
- One sub-module: accum_mem_pipe, a LATENCY-deep resp_t shift register with async active-low reset.
- The top holds the array, address decode, forwarding and req_count.

Test Plan:
- Preload via wr port: addr 0x0000<=0x11, 0x0004<=0x22, 0x0008<=0x33. Back-to-back reads of 0,4,8 with LATENCY=1 -> memresp_data 0x11,0x22,0x33 on consecutive cycles, memresp_val=1 each, err=0.
- LATENCY=3, single read of 0x0004 at edge N -> memresp_val=1 only at cycle N+3 with data 0x22; val=0 at N+1 and N+2.
- Read 0x0006 (misaligned) and, with DEPTH=1024, read 0x1000 (index 1024) -> memresp_val=1, err=1, data=0; req_count increments by 2.
- Same cycle: wr_val=1 to 0x0010 with 0xDEADBEEF, plus memreq to 0x0010 -> response data 0xDEADBEEF. Next cycle, re-read -> 0xDEADBEEF.
- Issue 3 reads with LATENCY=3, then pull rst low mid-flight -> outputs go 0 immediately (before the next edge) and stay 0 after release. A subsequent read of 0x0000 still returns 0x11.
- Drive the accumulate accelerator with size=3 over the preloaded 0x11, 0x22, 0x33 -> result=0x66 with result_val=1; req_count=3.
